parity_checker_rx: RTL and testbench

Serial receive-side parity checker: the checking end of the even-parity scheme our combinational parity generator produces. Accepts a bit-serial frame of WIDTH data bits (LSB first) followed by one parity bit. Reassembles the word, checks the parity bit against the accumulated data parity, and emits the word with an error flag. Keeps a saturating count of parity errors. Sits between a serial link front-end and the word-level datapath.

---
 rtl/parity_pkg.sv | 18 +
 rtl/parity_checker_rx_if.sv | 27 ++
 rtl/parity_err_counter.sv | 26 ++
 rtl/parity_checker_rx.sv | 98 +++++++++
 tb/tb_parity_checker_rx.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity-check receive path.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_ERR_CNT_W = 8;

  // Bit counter must reach WIDTH, hence the +1.
  function automatic int bit_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/parity_checker_rx_if.sv
// Bundle of the serial input, word output and error-count signals of parity_checker_rx.
// Handshake: in_valid qualifies in_start/in_bit for one cycle, with no back-pressure;
// out_valid is a one-cycle pulse and out_data/out_parity_err hold until the next pulse.
interface parity_checker_rx_if #(
  parameter int WIDTH     = 16,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_start;
  logic                 in_bit;
  logic                 clr_err;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_parity_err;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 busy;

  modport master (
    output in_valid, in_start, in_bit, clr_err,
    input  out_valid, out_data, out_parity_err, err_count, busy
  );

  modport slave (
    input  in_valid, in_start, in_bit, clr_err,
    output out_valid, out_data, out_parity_err, err_count, busy
  );
endinterface

// File: rtl/parity_err_counter.sv
// Saturating error counter; a synchronous clear beats a coincident increment.
module parity_err_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/parity_checker_rx.sv
// Reassembles LSB-first serial frames of WIDTH data bits plus an even-parity bit,
// flags parity errors and counts them.
module parity_checker_rx
  import parity_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  parity_checker_rx_if.slave  bus,
  output state_t              o_dbg_state
);

  localparam int CNT_W = bit_cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;
  logic             r_busy;

  logic                 w_restart;
  logic                 w_par_bit;
  logic                 w_err_inc;
  logic [ERR_CNT_W-1:0] w_err_count;

  // A start bit always wins, including over a parity bit in PARITY.
  assign w_restart = bus.in_valid && bus.in_start;
  assign w_par_bit = bus.in_valid && !bus.in_start && (r_state == PARITY);
  assign w_err_inc = w_par_bit && (r_par ^ bus.in_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_par       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_restart) begin
        // Bits enter at the MSB and shift down, so bit 0 lands at position 0 after WIDTH bits.
        r_shreg <= {bus.in_bit, {(WIDTH-1){1'b0}}};
        r_par   <= bus.in_bit;
        r_cnt   <= CNT_W'(1);
        r_state <= DATA;
        r_busy  <= 1'b1;
      end else if (bus.in_valid) begin
        case (r_state)
          DATA: begin
            r_shreg <= {bus.in_bit, r_shreg[WIDTH-1:1]};
            r_par   <= r_par ^ bus.in_bit;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_state <= PARITY;
            end
          end
          PARITY: begin
            r_out_data  <= r_shreg;
            r_out_err   <= r_par ^ bus.in_bit;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  parity_err_counter #(
    .W (ERR_CNT_W)
  ) u_err_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_err_inc),
    .i_clr   (bus.clr_err),
    .o_count (w_err_count)
  );

  assign bus.out_valid      = r_out_valid;
  assign bus.out_data       = r_out_data;
  assign bus.out_parity_err = r_out_err;
  assign bus.err_count      = w_err_count;
  assign bus.busy           = r_busy;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_parity_checker_rx.sv
// Directed bench for parity_checker_rx: frame table, abort, saturation, clear and reset cases.
module tb_parity_checker_rx;
  import parity_pkg::*;

  localparam int WIDTH     = 16;
  localparam int ERR_CNT_W = 8;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  parity_checker_rx_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

  parity_checker_rx #(
    .WIDTH     (WIDTH),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [WIDTH:0] exp_q[$];   // {parity_err, data}
  logic           prev_valid = 1'b0;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      check("out_valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        check("sb_out_data", {16'd0, bus.out_data}, {16'd0, e[WIDTH-1:0]});
        check("sb_out_parity_err", {31'd0, bus.out_parity_err}, {31'd0, e[WIDTH]});
      end
    end
    prev_valid = bus.out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    bus.in_bit   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Sends nbits bits of a frame (WIDTH+1 = complete frame with parity bit).
  task automatic send_frame(input logic [WIDTH-1:0] d, input logic par, input logic stall,
                            input logic clr_on_par, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.in_valid = 1'b1;
      bus.in_start = (i == 0);
      bus.in_bit   = (i < WIDTH) ? d[i] : par;
      bus.clr_err  = (i == WIDTH) && clr_on_par;
      @(negedge clk);
      bus.clr_err = 1'b0;
      if (i < WIDTH) begin
        check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
        check("no_valid_in_frame", {31'd0, bus.out_valid}, 32'd0);
        if (stall) begin
          bus.in_valid = 1'b0;
          bus.in_bit   = ~bus.in_bit;
          @(negedge clk);
          check("busy_in_stall", {31'd0, bus.busy}, 32'd1);
          check("no_valid_in_stall", {31'd0, bus.out_valid}, 32'd0);
        end
      end
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [WIDTH-1:0]     data;
    logic                 par;
    logic                 stall;
    logic                 exp_err;
    logic [ERR_CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];
  logic [ERR_CNT_W-1:0] model_cnt;

  initial begin
    vecs[0] = '{16'hA5A5, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{16'h0001, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[2] = '{16'h0001, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[3] = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[4] = '{16'h8001, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[5] = '{16'h7FFF, 1'b1, 1'b1, 1'b0, 8'd2};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    bus.in_bit   = 1'b0;
    bus.clr_err  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
    check("rst_out_err", {31'd0, bus.out_parity_err}, 32'd0);
    check("rst_err_count", {24'd0, bus.err_count}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;

    // Table frames, back to back with no dead cycle between them.
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back({vecs[v].exp_err, vecs[v].data});
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stall, 1'b0, WIDTH + 1);
      check("out_valid_after_parity", {31'd0, bus.out_valid}, 32'd1);
      check("out_data", {16'd0, bus.out_data}, {16'd0, vecs[v].data});
      check("out_parity_err", {31'd0, bus.out_parity_err}, {31'd0, vecs[v].exp_err});
      check("err_count", {24'd0, bus.err_count}, {24'd0, vecs[v].exp_cnt});
      check("busy_after_parity", {31'd0, bus.busy}, 32'd0);
    end
    idle(2);
    check("out_valid_one_pulse", {31'd0, bus.out_valid}, 32'd0);
    check("out_data_held", {16'd0, bus.out_data}, 32'h7FFF);

    // Abort at data bit 7, restart with 16'h1234.
    send_frame(16'hFFFF, 1'b0, 1'b0, 1'b0, 7);
    exp_q.push_back({1'b0, 16'h1234});
    send_frame(16'h1234, 1'b1, 1'b0, 1'b0, WIDTH + 1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("abort_out_data", {16'd0, bus.out_data}, 32'h1234);
    check("abort_out_err", {31'd0, bus.out_parity_err}, 32'd0);
    idle(1);

    // Start bit presented in place of the parity bit: frame discarded and restarted.
    send_frame(16'h00F0, 1'b0, 1'b0, 1'b0, WIDTH);
    exp_q.push_back({1'b1, 16'h0003});
    send_frame(16'h0003, 1'b1, 1'b0, 1'b0, WIDTH + 1);
    check("par_abort_data", {16'd0, bus.out_data}, 32'h0003);
    check("par_abort_count", {24'd0, bus.err_count}, 32'd3);
    idle(1);

    // Saturation: 300 bad frames on top of the current count.
    model_cnt = 8'd3;
    for (int f = 0; f < 300; f++) begin
      exp_q.push_back({1'b1, 16'h0000});
      send_frame(16'h0000, 1'b1, 1'b0, 1'b0, WIDTH + 1);
      if (model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
    end
    check("err_count_saturated", {24'd0, bus.err_count}, {24'd0, model_cnt});
    idle(1);
    check("err_count_still_saturated", {24'd0, bus.err_count}, 32'd255);

    // Clear coinciding with a bad frame's parity bit: clear wins.
    exp_q.push_back({1'b1, 16'h0100});
    send_frame(16'h0100, 1'b0, 1'b0, 1'b1, WIDTH + 1);
    check("clr_wins", {24'd0, bus.err_count}, 32'd0);
    check("clr_frame_err", {31'd0, bus.out_parity_err}, 32'd1);
    idle(1);

    // Reset after 5 data bits.
    send_frame(16'h001F, 1'b1, 1'b0, 1'b0, 5);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_data", {16'd0, bus.out_data}, 32'd0);
    check("mid_rst_out_err", {31'd0, bus.out_parity_err}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 16'h8000});
    send_frame(16'h8000, 1'b1, 1'b0, 1'b0, WIDTH + 1);
    check("post_rst_data", {16'd0, bus.out_data}, 32'h8000);
    check("post_rst_err", {31'd0, bus.out_parity_err}, 32'd0);
    check("post_rst_count", {24'd0, bus.err_count}, 32'd0);
    idle(3);

    check("sb_queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
